// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and hex decode for the 4-digit 7-segment scan driver.
// All segment and anode values here are active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Bit order of the result is {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] s;
    case (nibble)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low {g..a} segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode driver with blanking gaps, per-frame
// input snapshot and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SHOW_CYCLES  = 49984,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_in,
  input  logic       zero_blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  scan_state_t      state, state_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             need_start, need_start_n;
  logic             snap;

  logic [3:0][3:0]  sh_digit;
  logic [3:0]       sh_dp;
  logic             sh_zb;

  logic [3:0]       suppress;
  logic [6:0]       cur_seg;
  logic             lit;
  logic [3:0]       an_n;
  logic [6:0]       seg_n;
  logic             dp_n;

  seg7_hex_decode u_decode (
    .nibble (sh_digit[idx]),
    .seg    (cur_seg)
  );

  // A digit is suppressed only if it and every digit to its left are zero
  always_comb begin
    suppress    = 4'b0000;
    suppress[3] = sh_zb && (sh_digit[3] == 4'h0);
    suppress[2] = suppress[3] && (sh_digit[2] == 4'h0);
    suppress[1] = suppress[2] && (sh_digit[1] == 4'h0);
  end

  // need_start forces a fresh frame (with snapshot) after reset or re-enable
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    need_start_n = need_start;
    snap         = 1'b0;

    if (!enable) begin
      state_n      = ST_BLANK;
      idx_n        = 2'd0;
      cnt_n        = '0;
      need_start_n = 1'b1;
    end else if (need_start) begin
      state_n      = ST_BLANK;
      idx_n        = 2'd0;
      cnt_n        = '0;
      need_start_n = 1'b0;
      snap         = 1'b1;
    end else if (state == ST_BLANK) begin
      if (cnt == BLANK_LAST) begin
        state_n = ST_SHOW;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + CNT_ONE;
      end
    end else begin
      if (cnt == SHOW_LAST) begin
        state_n = ST_BLANK;
        cnt_n   = '0;
        idx_n   = idx + 2'd1;
        snap    = (idx == 2'd3);
      end else begin
        cnt_n = cnt + CNT_ONE;
      end
    end
  end

  // Pin values are derived from the next state so they change on the same edge
  always_comb begin
    lit   = (state_n == ST_SHOW) && !suppress[idx];
    an_n  = AN_OFF;
    seg_n = SEG_OFF;
    dp_n  = 1'b1;
    if (lit) begin
      an_n  = ~(4'b0001 << idx);
      seg_n = cur_seg;
      dp_n  = ~sh_dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BLANK;
      idx        <= 2'd0;
      cnt        <= '0;
      need_start <= 1'b1;
      sh_digit   <= '0;
      sh_dp      <= 4'b0000;
      sh_zb      <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      need_start <= need_start_n;
      an         <= an_n;
      seg        <= seg_n;
      dp         <= dp_n;
      frame_tick <= snap;
      if (snap) begin
        sh_digit <= {digit3, digit2, digit1, digit0};
        sh_dp    <= dp_in;
        sh_zb    <= zero_blank;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SHOW_CYCLES=4, BLANK_CYCLES=2 (24-cycle frame).
module tb_seg7_scan_driver;

  localparam logic [6:0] S_0 = 7'b1000000;
  localparam logic [6:0] S_1 = 7'b1111001;
  localparam logic [6:0] S_2 = 7'b0100100;
  localparam logic [6:0] S_3 = 7'b0110000;
  localparam logic [6:0] S_4 = 7'b0011001;
  localparam logic [6:0] S_5 = 7'b0010010;
  localparam logic [6:0] S_8 = 7'b0000000;
  localparam logic [6:0] S_A = 7'b0001000;
  localparam logic [6:0] S_B = 7'b0000011;
  localparam logic [6:0] S_C = 7'b1000110;
  localparam logic [6:0] S_D = 7'b0100001;
  localparam logic [6:0] S_F = 7'b0001110;
  localparam logic [6:0] OFF = 7'h7F;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] dp_in;
  logic       zero_blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .SHOW_CYCLES  (4),
    .BLANK_CYCLES (2),
    .CNT_W        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .dp_in      (dp_in),
    .zero_blank (zero_blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [3:0] d3, input logic [3:0] d2,
                                input logic [3:0] d1, input logic [3:0] d0,
                                input logic [3:0] dpm, input logic zb);
    digit3     = d3;
    digit2     = d2;
    digit1     = d1;
    digit0     = d0;
    dp_in      = dpm;
    zero_blank = zb;
  endtask

  task automatic check_output(input string tag, input logic [3:0] e_an,
                              input logic [6:0] e_seg, input logic e_dp,
                              input logic e_ft);
    checks++;
    assert (an === e_an) else begin
      errors++;
      $error("[TB] FAIL %s an observed=%b expected=%b", tag, an, e_an);
    end
    checks++;
    assert (seg === e_seg) else begin
      errors++;
      $error("[TB] FAIL %s seg observed=%b expected=%b", tag, seg, e_seg);
    end
    checks++;
    assert (dp === e_dp) else begin
      errors++;
      $error("[TB] FAIL %s dp observed=%b expected=%b", tag, dp, e_dp);
    end
    checks++;
    assert (frame_tick === e_ft) else begin
      errors++;
      $error("[TB] FAIL %s frame_tick observed=%b expected=%b", tag, frame_tick, e_ft);
    end
  endtask

  task automatic run_blank(input string tag, input logic ft);
    for (int i = 0; i < 2; i++) begin
      step();
      check_output(tag, 4'hF, OFF, 1'b1, (i == 0) ? ft : 1'b0);
    end
  endtask

  task automatic run_show(input string tag, input logic [3:0] e_an,
                          input logic [6:0] e_seg, input logic e_dp, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_output(tag, e_an, e_seg, e_dp, 1'b0);
    end
  endtask

  // lit[i]=0 means slot i is expected fully dark; poke rewrites digit0 after the snapshot
  task automatic run_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dpm, input logic [3:0] lit,
                           input logic poke, input logic [3:0] poke_val);
    logic [3:0][6:0] sv;
    sv = {s3, s2, s1, s0};
    for (int i = 0; i < 4; i++) begin
      run_blank(tag, (i == 0));
      if (i == 0 && poke) digit0 = poke_val;
      if (lit[i])
        run_show(tag, ~(4'b0001 << i), sv[i], ~dpm[i], 4);
      else
        run_show(tag, 4'hF, OFF, 1'b1, 4);
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    apply_stimulus(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, 1'b0);

    step();
    check_output("reset", 4'hF, OFF, 1'b1, 1'b0);
    step();
    check_output("reset_hold", 4'hF, OFF, 1'b1, 1'b0);
    rst = 1'b0;

    run_frame("f1_1234", S_4, S_3, S_2, S_1, 4'b0000, 4'hF, 1'b0, 4'h0);
    run_frame("f2_poke", S_4, S_3, S_2, S_1, 4'b0000, 4'hF, 1'b1, 4'hF);
    run_frame("f3_new",  S_F, S_3, S_2, S_1, 4'b0000, 4'hF, 1'b0, 4'h0);

    apply_stimulus(4'h0, 4'h0, 4'h5, 4'h0, 4'b0000, 1'b1);
    run_frame("zb_on_0050", S_0, S_5, OFF, OFF, 4'b0000, 4'b0011, 1'b0, 4'h0);
    zero_blank = 1'b0;
    run_frame("zb_off_0050", S_0, S_5, S_0, S_0, 4'b0000, 4'hF, 1'b0, 4'h0);

    apply_stimulus(4'h8, 4'h8, 4'h8, 4'h8, 4'b0100, 1'b0);
    run_frame("dp_8888", S_8, S_8, S_8, S_8, 4'b0100, 4'hF, 1'b0, 4'h0);

    apply_stimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b1);
    run_frame("zb_0000", S_0, OFF, OFF, OFF, 4'b0000, 4'b0001, 1'b0, 4'h0);

    apply_stimulus(4'h0, 4'h8, 4'h0, 4'h0, 4'b0000, 1'b1);
    run_frame("zb_0800", S_0, S_0, S_8, OFF, 4'b0000, 4'b0111, 1'b0, 4'h0);

    // Drop enable two cycles into the idx 2 slot
    run_blank("en_part", 1'b1);
    run_show("en_part", 4'b1110, S_0, 1'b1, 4);
    run_blank("en_part", 1'b0);
    run_show("en_part", 4'b1101, S_0, 1'b1, 4);
    run_blank("en_part", 1'b0);
    run_show("en_part", 4'b1011, S_8, 1'b1, 2);
    enable = 1'b0;
    apply_stimulus(4'hA, 4'hB, 4'hC, 4'hD, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("disabled", 4'hF, OFF, 1'b1, 1'b0);
    end
    enable = 1'b1;
    run_frame("reenable_abcd", S_D, S_C, S_B, S_A, 4'b0000, 4'hF, 1'b0, 4'h0);

    // Reset two cycles into SHOW of idx 0
    run_blank("rst_part", 1'b1);
    run_show("rst_part", 4'b1110, S_D, 1'b1, 2);
    rst = 1'b1;
    step();
    check_output("rst_mid_show", 4'hF, OFF, 1'b1, 1'b0);
    rst = 1'b0;
    apply_stimulus(4'h1, 4'h2, 4'h3, 4'h4, 4'b0001, 1'b0);
    run_frame("post_rst", S_4, S_3, S_2, S_1, 4'b0001, 4'hF, 1'b0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Drives a 4-digit, common-anode 7-segment display from the four nibbles produced by the display selector: digit0 (rightmost) through digit3 (leftmost).
- Time-multiplexes the digits with a programmable refresh slot and a blanking gap between digits to prevent ghosting.
- Snapshots all inputs once per frame so a displayed frame never mixes old and new values.
- Sits between the display-select mux and the board segment/anode pins.

Parameters:
- SHOW_CYCLES, 49984, clk cycles each digit is lit per slot (must be >= 1).
- BLANK_CYCLES, 16, clk cycles all anodes are off before each digit (must be >= 1).
- CNT_W, 16, slot counter width; must satisfy 2^CNT_W > max(SHOW_CYCLES, BLANK_CYCLES).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  1 = scanning; 0 = display dark
- digit0  in  4  rightmost nibble (bits 3:0 of the displayed word)
- digit1  in  4  bits 7:4
- digit2  in  4  bits 11:8
- digit3  in  4  leftmost nibble, bits 15:12
- dp_in  in  4  decimal point request per digit, bit i = digit i, 1 = on
- zero_blank  in  1  1 = suppress leading zeros
- an  out  4  anode enables, active-low, an[i] = digit i
- seg  out  7  segments, active-low, {g,f,e,d,c,b,a}
- dp  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- States: BLANK, SHOW. A 2-bit digit index idx and a slot counter cnt are kept alongside the state.
- Reset (rst=1 at a clk edge): an=4'b1111, seg=7'h7F, dp=1, frame_tick=0, state=BLANK, idx=0, cnt=0, shadow registers=0. Reset mid-slot aborts the slot immediately.
- BLANK state:
  - an=4'b1111, seg=7'h7F, dp=1.
  - Lasts exactly BLANK_CYCLES cycles (cnt 0..BLANK_CYCLES-1), then goes to SHOW with cnt=0.
- SHOW state:
  - Lasts exactly SHOW_CYCLES cycles, then goes to BLANK with idx=idx+1, wrapping 3->0.
  - an = ~(4'b0001 << idx); seg = hex decode of shadow digit[idx]; dp = ~shadow_dp[idx].
- Slot and frame timing: one slot = BLANK_CYCLES + SHOW_CYCLES cycles; one frame = 4 slots.
- Output registration: an, seg, dp and frame_tick are registered. Each takes its new value on the same edge the state changes, so there is no combinational glitch on the pins.
- Snapshot:
  - Taken on the edge that enters BLANK with idx=0, including the first BLANK after reset or after enable rises.
  - Captures digit0..3, dp_in and zero_blank.
  - frame_tick=1 for exactly that one cycle.
  - Input changes between snapshots are never visible on the outputs.
- Leading-zero suppression (shadow zero_blank=1):
  - Digit i (i = 3, 2, 1) is blanked when shadow digit i and every higher shadow digit are 0.
  - A blanked digit keeps an high, seg=7'h7F and dp=1 for its entire slot; slot timing is unchanged.
  - digit0 is never suppressed. Example: 0x0000 shows a single "0".
- enable=0: on the next edge, state=BLANK, idx=0, cnt=0, all outputs dark, frame_tick=0; shadow registers are held. On the edge where enable returns to 1, a new frame starts and a snapshot is taken.
- Hex decode, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Invariant: at most one an bit is low in any cycle; an==4'b1111 during every BLANK cycle.

Decomposition:
- Shared package seg7_pkg:
  - SEG_OFF = 7'h7F
  - AN_OFF = 4'hF
  - state encodings ST_BLANK, ST_SHOW
  - function hex_to_seg(nibble) returning the decode table above
- One natural sub-module: seg7_hex_decode (4-bit in, 7-bit active-low out), instantiated once on the idx-selected shadow digit.

Test Plan (SHOW_CYCLES=4, BLANK_CYCLES=2):
- Reset then digits {3..0}=4'h1,4'h2,4'h3,4'h4, dp_in=0, zero_blank=0, enable=1:
  - frame_tick pulses on the first BLANK edge.
  - Sequence per slot: 2 cycles an=1111, then 4 cycles an=1110 with seg=0011001 ("4"); then an=1101 "3", an=1011 "2", an=0111 "1".
  - Period is 24 cycles.
- Change digit0 to 4'hF mid-frame: the current frame still shows "4" in slot 0 of that frame; "F" (0001110) appears only after the next frame_tick.
- Digits 0x0050, zero_blank=1: slots 3 and 2 keep an=1111 throughout; slot 1 shows "5", slot 0 shows "0". Same input with zero_blank=0 shows all four digits.
- dp_in=4'b0100, digits 0x8888: dp=0 only while an=1011; seg=0000000 in every SHOW cycle.
- enable dropped during SHOW of idx 2: next cycle an=1111, seg=7F, dp=1. On re-enable, frame_tick pulses and scanning restarts at idx 0.
- rst asserted mid-SHOW: next cycle all outputs are at their reset values; after release, the first frame starts with a snapshot and frame_tick=1.
